// File: rtl/wvb_reader_stream.sv
// Round-robin reader of N waveform buffers; each frame streams its header words, then its samples, through a first-word fall-through output FIFO.
// Define WVB_RDR_CHAN_MASK_EN to add the chan_mask input, which excludes channels from arbitration (the mask is sampled in IDLE only).
module wvb_reader_stream #(
  parameter int N_CHANNELS   = 8,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_LEN_WIDTH  = 12,
  parameter int P_OUT_WIDTH  = 32,
  parameter int P_HDR_LAT    = 3,
  parameter int P_RD_LAT     = 2,
  parameter int P_FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
`ifdef WVB_RDR_CHAN_MASK_EN
  input  logic [N_CHANNELS-1:0]            chan_mask,
`endif
  input  logic [N_CHANNELS-1:0]            hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]            hdr_rdreq,
  output logic [N_CHANNELS-1:0]            wvb_rdreq,
  output logic [N_CHANNELS-1:0]            wvb_rddone,
  output logic [P_OUT_WIDTH-1:0]           out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic [4:0]                       out_chan,
  output logic                             busy
);
  localparam int H   = (P_HDR_WIDTH + P_OUT_WIDTH - 1) / P_OUT_WIDTH;
  localparam int HPW = H * P_OUT_WIDTH;
  localparam int CW  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int AW  = $clog2(P_FIFO_DEPTH);
  localparam int HCW = $clog2(P_HDR_LAT + H + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR_WAIT, S_HDR_EMIT, S_SAMP, S_DONE} state_t;

  typedef struct packed {
    logic [P_OUT_WIDTH-1:0] dat;
    logic                   sof;
    logic                   eof;
    logic [4:0]             chan;
  } ent_t;

  state_t state, state_nxt;
  logic [CW-1:0]          sel, rr_ptr, gnt_idx;
  logic                   gnt_found, grant;
  logic [N_CHANNELS-1:0]  elig;
  logic [HPW-1:0]         hdr_q;
  logic [P_LEN_WIDTH-1:0] len, issued;
  logic [HCW-1:0]         cnt;
  logic [P_RD_LAT-1:0]    rd_vld_sr, rd_eof_sr;
  int                     outstanding;
  logic                   rd_issue, push_hdr, last_hdr_word, push, pop, fifo_full;
  ent_t                   push_ent, head;
  ent_t                   mem [P_FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [AW:0]            fifo_count;
  logic [P_HDR_WIDTH-1:0] hdr_slice;
  logic [P_DATA_WIDTH-1:0] samp_slice;

  // Work-conserving search: first eligible channel after the last one served.
  always_comb begin
    int j;
`ifdef WVB_RDR_CHAN_MASK_EN
    elig = ~hdr_empty & chan_mask;
`else
    elig = ~hdr_empty;
`endif
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      j = int'(rr_ptr) + 1 + k;
      if (j >= N_CHANNELS) j = j - N_CHANNELS;
      if (!gnt_found && elig[CW'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(j);
      end
    end
  end

  assign grant         = (state == S_IDLE) && en && gnt_found;
  assign hdr_slice     = hdr_data[int'(sel)*P_HDR_WIDTH +: P_HDR_WIDTH];
  assign samp_slice    = wvb_data[int'(sel)*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign outstanding   = $countones(rd_vld_sr);
  assign fifo_full     = (fifo_count == (AW+1)'(P_FIFO_DEPTH));
  assign push_hdr      = (state == S_HDR_EMIT) && !fifo_full;
  assign last_hdr_word = (cnt == HCW'(H - 1));

  // Credit rule: FIFO occupancy plus reads in flight never exceeds the depth.
  assign rd_issue = (state == S_SAMP) && !rst && (issued < len) &&
                    (int'(fifo_count) + outstanding < P_FIFO_DEPTH);

  always_comb begin
    wvb_rdreq      = '0;
    wvb_rdreq[sel] = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (grant) state_nxt = S_HDR_WAIT;
      S_HDR_WAIT: if (cnt == HCW'(P_HDR_LAT)) state_nxt = S_HDR_EMIT;
      S_HDR_EMIT: if (push_hdr && last_hdr_word) state_nxt = (len == '0) ? S_DONE : S_SAMP;
      S_SAMP:     if (issued == len) state_nxt = S_DONE;
      S_DONE:     if (outstanding == 0) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      rr_ptr     <= CW'(N_CHANNELS - 1);
      cnt        <= '0;
      len        <= '0;
      issued     <= '0;
      hdr_q      <= '0;
      hdr_rdreq  <= '0;
      wvb_rddone <= '0;
    end else begin
      hdr_rdreq  <= '0;
      wvb_rddone <= '0;
      case (state)
        S_IDLE: if (grant) begin
          sel                <= gnt_idx;
          rr_ptr             <= gnt_idx;
          hdr_rdreq[gnt_idx] <= 1'b1;
          cnt                <= '0;
          issued             <= '0;
        end
        S_HDR_WAIT: if (cnt == HCW'(P_HDR_LAT)) begin
          hdr_q <= HPW'(hdr_slice);
          len   <= hdr_slice[P_LEN_WIDTH-1:0];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_HDR_EMIT: if (push_hdr) cnt <= cnt + 1'b1;
        S_SAMP:     if (rd_issue) issued <= issued + 1'b1;
        S_DONE:     if (outstanding == 0) wvb_rddone[sel] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag travels with each read so the returning word knows whether it ends the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_sr <= '0;
      rd_eof_sr <= '0;
    end else begin
      rd_vld_sr[0] <= rd_issue;
      rd_eof_sr[0] <= rd_issue && ((issued + 1'b1) == len);
      for (int k = 1; k < P_RD_LAT; k++) begin
        rd_vld_sr[k] <= rd_vld_sr[k-1];
        rd_eof_sr[k] <= rd_eof_sr[k-1];
      end
    end
  end

  always_comb begin
    push     = 1'b0;
    push_ent = '0;
    if (push_hdr) begin
      push          = 1'b1;
      push_ent.dat  = hdr_q[int'(cnt)*P_OUT_WIDTH +: P_OUT_WIDTH];
      push_ent.sof  = (cnt == '0);
      push_ent.eof  = last_hdr_word && (len == '0);
      push_ent.chan = 5'(sel);
    end else if (rd_vld_sr[P_RD_LAT-1]) begin
      push          = 1'b1;
      push_ent.dat  = P_OUT_WIDTH'(samp_slice);
      push_ent.eof  = rd_eof_sr[P_RD_LAT-1];
      push_ent.chan = 5'(sel);
    end
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rptr];
  assign out_data  = out_valid ? head.dat  : '0;
  assign out_sof   = out_valid ? head.sof  : 1'b0;
  assign out_eof   = out_valid ? head.eof  : 1'b0;
  assign out_chan  = out_valid ? head.chan : 5'd0;
  assign busy      = (state != S_IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_wvb_reader_stream.sv
// Directed bench for wvb_reader_stream: single frame, round-robin order, backpressure, len=0, enable gating, reset mid-frame.
`timescale 1ns/1ps
module tb_wvb_reader_stream;
  localparam int N = 8;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, out_ready = 1'b0;
  logic [N-1:0]    hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [N*80-1:0] hdr_data;
  logic [N*22-1:0] wvb_data;
  logic [31:0]     out_data;
  logic            out_valid, out_sof, out_eof, busy;
  logic [4:0]      out_chan;
`ifdef WVB_RDR_CHAN_MASK_EN
  logic [N-1:0]    chan_mask = '1;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  wvb_reader_stream dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef WVB_RDR_CHAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .hdr_empty(hdr_empty), .hdr_data(hdr_data), .wvb_data(wvb_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .out_chan(out_chan), .busy(busy)
  );

  function automatic logic [21:0] smp(input int c, input int i);
    return {1'b1, 5'(c), 16'(i + 4096)};
  endfunction

  function automatic logic [31:0] hdr_word(input int c, input int len, input int k);
    logic [95:0] v;
    v = {16'd0, 8'hA0 + 8'(c), 60'hFEDCBA987654321, 12'(len)};
    return v[k*32 +: 32];
  endfunction

  // Header FIFO and sample store models.
  logic [N-1:0] fill = '0;
  logic [11:0]  hdr_len [N];
  int           hdr_cnt [N] = '{default: 0};
  int           sidx [N] = '{default: 0};
  logic [21:0]  d0 [N], d1 [N];

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      hdr_cnt[c] <= hdr_cnt[c] + int'(fill[c]) - int'(hdr_rdreq[c]);
      if (hdr_rdreq[c])      sidx[c] <= 0;
      else if (wvb_rdreq[c]) sidx[c] <= sidx[c] + 1;
      if (wvb_rdreq[c]) d0[c] <= smp(c, sidx[c]);
      d1[c] <= d0[c];
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_ch
    assign hdr_empty[c]         = (hdr_cnt[c] == 0);
    assign hdr_data[c*80 +: 80] = {8'hA0 + 8'(c), 60'hFEDCBA987654321, hdr_len[c]};
    assign wvb_data[c*22 +: 22] = d1[c];
  end

  // Monitor: records transfers as {sof, eof, chan, data}, counts strobes, flags unstable stalled words.
  logic        clr = 1'b0;
  logic [38:0] cur, prev_word = '0;
  logic        prev_stall = 1'b0;
  logic [38:0] rec [512];
  int cyc = 0, nrec = 0, dn_total = 0, stall_viol = 0, nh = 0, last_dn = 0;
  int hr_cnt [N], wr_cnt [N], dn_cnt [N], gap [16];
  assign cur = {out_sof, out_eof, out_chan, out_data};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      nrec <= 0; dn_total <= 0; stall_viol <= 0; nh <= 0; last_dn <= 0; prev_stall <= 1'b0;
      for (int c = 0; c < N; c++) begin
        hr_cnt[c] <= 0; wr_cnt[c] <= 0; dn_cnt[c] <= 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        hr_cnt[c] <= hr_cnt[c] + int'(hdr_rdreq[c]);
        wr_cnt[c] <= wr_cnt[c] + int'(wvb_rdreq[c]);
        dn_cnt[c] <= dn_cnt[c] + int'(wvb_rddone[c]);
      end
      if (|hdr_rdreq) begin
        if (nh < 16) gap[nh] <= cyc - last_dn;
        nh <= nh + 1;
      end
      if (|wvb_rddone) begin
        last_dn  <= cyc;
        dn_total <= dn_total + 1;
      end
      if (out_valid && out_ready && nrec < 512) begin
        rec[nrec] <= cur;
        nrec      <= nrec + 1;
      end
      if (prev_stall && cur !== prev_word) stall_viol <= stall_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_word  <= cur;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag, input bit bp);
    int k = 0;
    while (k < budget && !(dn_total >= n && !busy)) begin
      if (bp) out_ready = (k % 4 == 0);
      tick(1);
      k++;
    end
    check({tag, "_done"}, 64'(k < budget), 64'd1);
  endtask

  task automatic check_frame(input int base, input int c, input int len, input string tag);
    for (int k = 0; k < len + 3; k++) begin
      logic [31:0] d;
      d = (k < 3) ? hdr_word(c, len, k) : {10'd0, smp(c, k - 3)};
      check(tag, 64'(rec[base + k]), {25'd0, (k == 0), (k == len + 2), 5'(c), d});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < N; c++) hdr_len[c] = 12'd0;
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    clear();
    tick(3);
    check("rst_valid",   64'(out_valid), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_strobes", 64'({hdr_rdreq, wvb_rdreq, wvb_rddone}), 64'd0);
    check("rst_word",    64'(cur), 64'd0);
    rst = 1'b0;
    tick(1);

    // Single frame on channel 3, len 5
    hdr_len[3] = 12'd5;
    clear();
    fill = 8'h08; tick(1); fill = '0;
    wait_frames(1, 200, "single", 1'b0);
    check("single_nrec", 64'(nrec), 64'd8);
    check("single_w0", 64'(rec[0]), 64'({1'b1, 1'b0, 5'd3, 32'h54321005}));
    check("single_w1", 64'(rec[1]), 64'({1'b0, 1'b0, 5'd3, 32'hDCBA9876}));
    check("single_w2", 64'(rec[2]), 64'({1'b0, 1'b0, 5'd3, 32'h0000A3FE}));
    check("single_w3", 64'(rec[3]), 64'({1'b0, 1'b0, 5'd3, 32'h00231000}));
    check("single_w7", 64'(rec[7]), 64'({1'b0, 1'b1, 5'd3, 32'h00231004}));
    check_frame(0, 3, 5, "single_frame");
    check("single_hdr_rdreq", 64'(hr_cnt[3]), 64'd1);
    check("single_wvb_rdreq", 64'(wr_cnt[3]), 64'd5);
    check("single_rddone",    64'(dn_cnt[3]), 64'd1);
    check("single_total_hdr", 64'(nh), 64'd1);

    // Round-robin from reset pointer: channels 0, 2, 7
    rst = 1'b1; tick(2); rst = 1'b0;
    hdr_len[0] = 12'd2; hdr_len[2] = 12'd2; hdr_len[7] = 12'd2;
    clear();
    fill = 8'h85; tick(1); fill = '0;
    wait_frames(3, 300, "rr", 1'b0);
    check("rr_nrec", 64'(nrec), 64'd15);
    check("rr_order0", 64'(rec[0][36:32]), 64'd0);
    check("rr_order1", 64'(rec[5][36:32]), 64'd2);
    check("rr_order2", 64'(rec[10][36:32]), 64'd7);
    check_frame(0, 0, 2, "rr_f0");
    check_frame(5, 2, 2, "rr_f2");
    check_frame(10, 7, 2, "rr_f7");
    check("rr_gap1", 64'(gap[1] <= 2), 64'd1);
    check("rr_gap2", 64'(gap[2] <= 2), 64'd1);
    // Pointer is at 7: wrap serves 0 before 7
    clear();
    fill = 8'h81; tick(1); fill = '0;
    wait_frames(2, 300, "rr_wrap", 1'b0);
    check("rr_wrap_first",  64'(rec[0][36:32]), 64'd0);
    check("rr_wrap_second", 64'(rec[5][36:32]), 64'd7);

    // Backpressure: len 20, ready 1 of every 4 cycles
    hdr_len[5] = 12'd20;
    clear();
    fill = 8'h20; tick(1); fill = '0;
    wait_frames(1, 1500, "bp", 1'b1);
    out_ready = 1'b1;
    check("bp_nrec", 64'(nrec), 64'd23);
    check_frame(0, 5, 20, "bp_frame");
    check("bp_stable", 64'(stall_viol), 64'd0);
    check("bp_rdreq",  64'(wr_cnt[5]), 64'd20);

    // Zero-length frame on channel 1
    hdr_len[1] = 12'd0;
    clear();
    fill = 8'h02; tick(1); fill = '0;
    wait_frames(1, 200, "len0", 1'b0);
    check("len0_nrec", 64'(nrec), 64'd3);
    check_frame(0, 1, 0, "len0_frame");
    check("len0_rdreq",  64'(wr_cnt[1]), 64'd0);
    check("len0_rddone", 64'(dn_cnt[1]), 64'd1);

    // Enable low blocks new grants
    en = 1'b0;
    hdr_len[2] = 12'd3;
    clear();
    fill = 8'h04; tick(1); fill = '0;
    tick(30);
    check("en0_no_grant", 64'(hr_cnt[2]), 64'd0);
    check("en0_idle",     64'({busy, out_valid}), 64'd0);
    en = 1'b1;
    wait_frames(1, 200, "en1", 1'b0);
    check_frame(0, 2, 3, "en1_frame");

    // Reset in the middle of a len-100 frame on channel 4
    hdr_len[4] = 12'd100;
    clear();
    fill = 8'h10; tick(1); fill = '0;
    begin
      int k = 0;
      while (k < 300 && wr_cnt[4] < 10) begin tick(1); k++; end
      check("mid_reached_samp", 64'(k < 300), 64'd1);
    end
    rst = 1'b1;
    tick(1);
    check("mid_valid",   64'(out_valid), 64'd0);
    check("mid_strobes", 64'({hdr_rdreq, wvb_rdreq, wvb_rddone}), 64'd0);
    check("mid_busy",    64'(busy), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("mid_no_rddone", 64'(dn_cnt[4]), 64'd0);
    hdr_len[1] = 12'd1; hdr_len[6] = 12'd1;
    clear();
    fill = 8'h42; tick(1); fill = '0;
    wait_frames(2, 300, "mid_after", 1'b0);
    check("mid_first_chan",  64'(rec[0][36:32]), 64'd1);
    check("mid_second_chan", 64'(rec[4][36:32]), 64'd6);
    check_frame(0, 1, 1, "mid_f1");
    check_frame(4, 6, 1, "mid_f6");

`ifdef WVB_RDR_CHAN_MASK_EN
    // Masked channel is never granted; unmasking grants promptly
    chan_mask = 8'b1111_1011;
    hdr_len[2] = 12'd1;
    clear();
    fill = 8'h04; tick(1); fill = '0;
    tick(20);
    check("mask_blocked", 64'(hr_cnt[2]), 64'd0);
    chan_mask = '1;
    tick(3);
    check("mask_grant", 64'(hr_cnt[2]), 64'd1);
    wait_frames(1, 200, "mask", 1'b0);
    check_frame(0, 2, 1, "mask_frame");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wvb_reader_stream.md
Name: wvb_reader_stream

Overview:
- Next-generation multi-channel waveform buffer reader. Serves N waveform buffers (header FIFO plus sample store per channel) with work-conserving round-robin arbitration.
- Emits each waveform as a framed valid/ready word stream: header words first, then one word per sample. This replaces the DPRAM hand-off with backpressure-aware streaming.
- Uses an internal output FIFO with credit-based read prefetch so that sample read latency is hidden while out_ready is held high.

Parameters:
N_CHANNELS, 8, number of waveform buffers served (1..32)
P_DATA_WIDTH, 22, sample width; must be <= P_OUT_WIDTH
P_HDR_WIDTH, 80, header width; sample count in bits [P_LEN_WIDTH-1:0]
P_LEN_WIDTH, 12, width of the sample-count field
P_OUT_WIDTH, 32, output word width
P_HDR_LAT, 3, cycles from hdr_rdreq to valid hdr_data
P_RD_LAT, 2, cycles from wvb_rdreq to valid wvb_data
P_FIFO_DEPTH, 8, output FIFO depth; power of 2, >= P_RD_LAT+2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  enable; gates the start of new frames only
hdr_empty  in  N_CHANNELS  per-channel header FIFO empty
hdr_data  in  N_CHANNELS*P_HDR_WIDTH  per-channel header, channel i at slice i
wvb_data  in  N_CHANNELS*P_DATA_WIDTH  per-channel sample data
hdr_rdreq  out  N_CHANNELS  one-hot header read pulse
wvb_rdreq  out  N_CHANNELS  one-hot sample read strobe
wvb_rddone  out  N_CHANNELS  one-hot end-of-waveform pulse
out_data  out  P_OUT_WIDTH  stream word
out_valid  out  1  word valid
out_ready  in  1  consumer ready; transfer = out_valid && out_ready
out_sof  out  1  first header word of a frame
out_eof  out  1  last word of a frame
out_chan  out  5  channel index of the current word
busy  out  1  high in every state other than IDLE, or while the FIFO is non-empty

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE, the FIFO is flushed, the credit counter is cleared, and rr_ptr (the last-served channel) is set to N_CHANNELS-1. A reset asserted mid-frame abandons the frame; no rddone pulse is issued.
- Arbitration (IDLE, en=1):
  - Combinationally select the first channel c with hdr_empty[c]=0, searching from rr_ptr+1 upward with wrap.
  - If none is found, stay in IDLE. Idle cycles are never spent visiting empty channels.
  - On a grant, register sel=c and rr_ptr=c, pulse hdr_rdreq[c] for exactly 1 cycle, and go to HDR_WAIT.
- HDR_WAIT:
  - Count P_HDR_LAT cycles, then capture hdr_data slice sel.
  - Set len = hdr[P_LEN_WIDTH-1:0] and go to HDR_EMIT.
- HDR_EMIT:
  - Push H = ceil(P_HDR_WIDTH/P_OUT_WIDTH) words, least-significant first, zero-padded.
  - One word is pushed per cycle while the FIFO is not full.
  - The first word is tagged sof. When len=0, the last header word is tagged eof.
  - Then go to SAMP, or to DONE if len=0.
- SAMP:
  - Assert wvb_rdreq[sel] in a cycle only when issued<len and (fifo_count + outstanding) < P_FIFO_DEPTH.
  - outstanding = reads in flight (0..P_RD_LAT).
  - Each read returns P_RD_LAT cycles later via a latency-matched shift register. The returned word is the sample zero-extended to P_OUT_WIDTH; the final sample is tagged eof.
  - Go to DONE when issued==len.
- DONE:
  - Wait until outstanding==0.
  - Pulse wvb_rddone[sel] for 1 cycle, then return to IDLE. The next grant may occur on the following cycle.
- Output FIFO:
  - First-word fall-through. out_valid = !empty.
  - out_data, out_sof, out_eof and out_chan are held stable while out_valid && !out_ready.
  - A push and a pop in the same cycle are both honoured, with count unchanged. The credit rule guarantees the FIFO never overflows.
- en=0: no new grant. A frame in progress completes normally, and the FIFO keeps draining.
- Throughput: with out_ready held at 1, one sample word per cycle in steady state. Frame overhead is at most P_HDR_LAT+H+P_RD_LAT+3 cycles.
- Maximum len is 2^P_LEN_WIDTH-1. The issued counter is P_LEN_WIDTH bits wide and does not wrap.

Optional Feature:
- WVB_RDR_CHAN_MASK_EN defined:
  - Adds input port chan_mask[N_CHANNELS-1:0]. A channel with chan_mask[c]=0 is excluded from arbitration.
  - The mask is sampled only in IDLE. Clearing a bit mid-frame does not abort that channel's frame.
- Not defined: all channels are eligible, and the port does not exist.

Test Plan:
- Single frame, defaults: channel 3 only, len=5, out_ready=1 -> 3 header words (sof on word 0), then 5 sample words (eof on the 5th), out_chan=3 on all 8 words; 1-cycle hdr_rdreq[3], 5 wvb_rdreq[3], 1 wvb_rddone[3].
- Round-robin: channels 0, 2 and 7 non-empty, len=2 each, rr_ptr reset -> frames in order 0, 2, 7, then 0 again if refilled; no idle cycles spent visiting empty channels.
- Backpressure: len=20, out_ready toggled 1 cycle high / 3 cycles low -> no word lost or duplicated; out_data stable while stalled; fifo_count+outstanding never exceeds 8.
- len=0: channel 1 header with length field 0 -> exactly 3 words, eof on word 2; no wvb_rdreq; wvb_rddone[1] pulses once.
- Reset mid-frame: rst asserted during SAMP of a len=100 frame -> next cycle out_valid=0, all strobes 0, no rddone; after release, a new grant occurs with the search starting at channel 0.
- Mask (WVB_RDR_CHAN_MASK_EN): chan_mask=8'b1111_1011 with channel 2 non-empty -> channel 2 is never granted; setting bit 2 gives a grant within 1 IDLE cycle.
